test_status_monitor: RTL and testbench
======================================

TEST_STATUS_MONITOR -- requirements
Module: test_status

Interface
REQ-001: Parameter PREFIX, string, default "TEST"; text label leading every status message.
REQ-002: Parameter TIMEOUT, integer, default 100000; cycle budget before timeout; 0 disables timeout.
REQ-003: Parameter CNT_WIDTH, integer, default 32; width of cycle_count.
REQ-004: Parameter FINISH_ON_DONE, integer, default 1; 1 = end simulation after a terminal message, 0 = keep running.
REQ-005: clk  input  1  sole clock; all state changes on its rising edge.
REQ-006: reset  input  1  asynchronous, active-high reset.
REQ-007: pass  input  1  level, sampled on rising clk; high = test passed.
REQ-008: fail  input  1  level, sampled on rising clk; high = test failed.
REQ-009: done  output  1  high while the monitor is in any terminal state.
REQ-010: status  output  2  00 RUNNING, 01 PASSED, 10 FAILED, 11 TIMED_OUT.
REQ-011: cycle_count  output  CNT_WIDTH  clock cycles elapsed in RUNNING since last reset.

Function
REQ-012: Four states SHALL exist: RUNNING, PASSED, FAILED, TIMED_OUT; status encodes the current state directly, registered.
REQ-013: In RUNNING, cycle_count SHALL increment by 1 on every rising clk and saturate at all-ones without wrapping.
REQ-014: RUNNING -> FAILED when fail=1 at a rising edge, regardless of pass.
REQ-015: RUNNING -> PASSED when pass=1 and fail=0 at a rising edge.
REQ-016: RUNNING -> TIMED_OUT when TIMEOUT!=0, pass=0, fail=0 and cycle_count==TIMEOUT-1 at a rising edge; done therefore rises exactly TIMEOUT cycles after reset release.
REQ-017: Priority on simultaneous events in one cycle: fail > pass > timeout.
REQ-018: Terminal states SHALL be sticky: pass, fail and timeout conditions are ignored until reset; cycle_count freezes at its value on entry.
REQ-019: done = 1 iff status != 00; done and status update in the same cycle (one-cycle latency after the sampling edge).
REQ-020: X or Z on pass/fail SHALL be treated as 0 for transitions and SHALL emit a warning message "<PREFIX>: WARNING pass/fail unknown at cycle N" once per occurrence cycle (simulation only).
REQ-021: On entry to PASSED, print once "<PREFIX>: TEST PASSED at cycle N" (N = cycle_count at the sampling edge).
REQ-022: On entry to FAILED, print once "<PREFIX>: TEST FAILED at cycle N".
REQ-023: On entry to TIMED_OUT, print once "<PREFIX>: TEST FAILED - TIMEOUT after TIMEOUT cycles".
REQ-024: When FINISH_ON_DONE=1, simulation SHALL finish one clock cycle after the terminal message, so done/status are observable for one cycle.
REQ-025: Message and finish logic SHALL be excluded from synthesis; the state/counter logic SHALL be synthesizable.

Reset
REQ-026: reset=1 SHALL immediately (asynchronously) force state RUNNING, status=00, done=0, cycle_count=0.
REQ-027: While reset=1, no counting, no transitions, no messages.
REQ-028: Reset asserted in any state, including mid-count or terminal, SHALL fully restart the monitor; a new terminal message may print after the restart.
REQ-029: First count occurs on the first rising clk after reset deasserts.

Verification
REQ-030: TIMEOUT=10, pass pulsed on 5th edge after reset -> status=01, done=1, cycle_count=4, one PASSED message, no further change when fail later pulses.
REQ-031: TIMEOUT=10, pass=fail=0 -> done rises after 10 edges, status=11, cycle_count=9, TIMEOUT message.
REQ-032: TIMEOUT=10, pass=1 and fail=1 on the same edge at cycle 3 -> status=10, cycle_count=3.
REQ-033: TIMEOUT=10, pass on the edge where cycle_count=9 -> status=01 (pass beats timeout).
REQ-034: Reset asserted between edges after reaching PASSED -> status=00, done=0, cycle_count=0 without a clock edge; then recount and timeout at 10.
REQ-035: TIMEOUT=0, CNT_WIDTH=4, no pass/fail for 40 cycles -> status stays 00, cycle_count saturates at 15.

Source files
------------

// File: rtl/test_status_monitor.sv
// rtl/test_status_monitor.sv - pass/fail/timeout status monitor for simulation test harnesses
//
// Purpose:
//   Watches a test's pass/fail levels and a cycle budget. It ends in one of
//   three sticky terminal states (PASSED, FAILED, TIMED_OUT) and optionally
//   prints a status line and ends the simulation.
//   The state and counter logic is synthesizable.
//   The message and finish logic is for simulation only.
//
// Parameters:
//   PREFIX         - label leading every status message
//   TIMEOUT        - cycle budget before timeout; 0 disables the timeout
//   CNT_WIDTH      - width of cycle_count
//   FINISH_ON_DONE - 1: $finish one cycle after the terminal message
//   MSG_ENABLE     - 1: print status/warning messages; 0: keep the console silent
//
// Ports:
//   clk         in   sole clock, rising edge
//   reset       in   asynchronous, active-high reset
//   pass        in   level, high = test passed
//   fail        in   level, high = test failed
//   done        out  high in any terminal state
//   status      out  00 RUNNING, 01 PASSED, 10 FAILED, 11 TIMED_OUT
//   cycle_count out  cycles spent in RUNNING since reset (saturating)

module test_status_monitor #(
    parameter string PREFIX         = "TEST",
    parameter int    TIMEOUT        = 100000,
    parameter int    CNT_WIDTH      = 32,
    parameter int    FINISH_ON_DONE = 1,
    parameter bit    MSG_ENABLE     = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pass,
    input  logic                 fail,
    output logic                 done,
    output logic [1:0]           status,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_RUNNING   = 2'b00,
        ST_PASSED    = 2'b01,
        ST_FAILED    = 2'b10,
        ST_TIMED_OUT = 2'b11
    } state_t;

    // The timeout compare is done at no less than 32 bits, so a TIMEOUT
    // larger than the counter range never matches. A counter that
    // saturates below TIMEOUT-1 never times out, and it does not alias
    // to a smaller value.
    localparam int                 EXT_W        = (CNT_WIDTH > 32) ? CNT_WIDTH : 32;
    localparam bit                 TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [EXT_W-1:0]   TIMEOUT_LAST = EXT_W'(TIMEOUT - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_cnt_inc;
    logic                 w_pass;
    logic                 w_fail;
    logic                 w_timeout_hit;
    logic [EXT_W-1:0]     w_cnt_ext;

    // An unknown level on pass or fail must not cause a transition.
    // Only a definite 1 counts.
    assign w_pass        = (pass === 1'b1);
    assign w_fail        = (fail === 1'b1);
    assign w_cnt_ext     = EXT_W'(r_cnt);
    assign w_timeout_hit = TIMEOUT_EN && (w_cnt_ext == TIMEOUT_LAST);

    // Next-state logic. The counter advances only on edges that stay in
    // RUNNING. On the edge that enters a terminal state, the counter keeps
    // the value that was sampled on that edge.
    always_comb begin
        w_next_state = r_state;
        w_cnt_inc    = 1'b0;
        case (r_state)
            ST_RUNNING: begin
                if (w_fail) begin
                    w_next_state = ST_FAILED;
                end else if (w_pass) begin
                    w_next_state = ST_PASSED;
                end else if (w_timeout_hit) begin
                    w_next_state = ST_TIMED_OUT;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_next_state = r_state;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUNNING;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_cnt_inc && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign status      = r_state;
    assign done        = (r_state != ST_RUNNING);
    assign cycle_count = r_cnt;

`ifndef SYNTHESIS
    // The finish request is held for one cycle after the terminal message.
    // This leaves done and status visible for one sampled cycle.
    logic r_finish_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_finish_pend <= 1'b0;
        end else begin
            if (r_finish_pend && (FINISH_ON_DONE != 0)) begin
                $finish;
            end
            if (r_state == ST_RUNNING) begin
                if (MSG_ENABLE && ($isunknown(pass) || $isunknown(fail))) begin
                    $display("%s: WARNING pass/fail unknown at cycle %0d", PREFIX, r_cnt);
                end
                if (w_next_state != ST_RUNNING) begin
                    r_finish_pend <= 1'b1;
                    if (MSG_ENABLE) begin
                        case (w_next_state)
                            ST_PASSED:
                                $display("%s: TEST PASSED at cycle %0d", PREFIX, r_cnt);
                            ST_FAILED:
                                $display("%s: TEST FAILED at cycle %0d", PREFIX, r_cnt);
                            default:
                                $display("%s: TEST FAILED - TIMEOUT after %0d cycles", PREFIX, TIMEOUT);
                        endcase
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_test_status_monitor.sv
// tb/tb_test_status_monitor.sv - directed self-checking bench for test_status_monitor

module tb_test_status_monitor;

    logic       clk;
    logic       rst_a, pass_a, fail_a, done_a;
    logic [1:0] status_a;
    logic [31:0] cnt_a;
    logic       rst_b, pass_b, fail_b, done_b;
    logic [1:0] status_b;
    logic [3:0] cnt_b;

    int n_vec;
    int n_bad;

    test_status_monitor #(
        .PREFIX("DUTA"), .TIMEOUT(10), .CNT_WIDTH(32),
        .FINISH_ON_DONE(0), .MSG_ENABLE(1'b0)
    ) u_dut_a (
        .clk(clk), .reset(rst_a), .pass(pass_a), .fail(fail_a),
        .done(done_a), .status(status_a), .cycle_count(cnt_a)
    );

    test_status_monitor #(
        .PREFIX("DUTB"), .TIMEOUT(0), .CNT_WIDTH(4),
        .FINISH_ON_DONE(0), .MSG_ENABLE(1'b1)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .pass(pass_b), .fail(fail_b),
        .done(done_b), .status(status_b), .cycle_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [1:0] st, input logic dn, input logic [31:0] cn);
        chk({tag, ".status"}, 32'(status_a), 32'(st));
        chk({tag, ".done"}, 32'(done_a), 32'(dn));
        chk({tag, ".cnt"}, cnt_a, cn);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_a = 1'b1; pass_a = 1'b0; fail_a = 1'b0;
        rst_b = 1'b1; pass_b = 1'b0; fail_b = 1'b0;

        #2;
        chk_a("reset_init", 2'b00, 1'b0, 32'd0);

        pass_a = 1'b1; fail_a = 1'b1;
        step(2);
        chk_a("hold_in_reset", 2'b00, 1'b0, 32'd0);

        // pass on the 5th edge after release
        pass_a = 1'b0; fail_a = 1'b0; rst_a = 1'b0;
        step(4);
        chk_a("count4", 2'b00, 1'b0, 32'd4);
        pass_a = 1'b1;
        step(1);
        chk_a("passed", 2'b01, 1'b1, 32'd4);
        pass_a = 1'b0; fail_a = 1'b1;
        step(3);
        chk_a("passed_sticky", 2'b01, 1'b1, 32'd4);
        fail_a = 1'b0;

        // asynchronous reset between edges, then timeout
        #2;
        rst_a = 1'b1;
        #1;
        chk_a("async_reset", 2'b00, 1'b0, 32'd0);
        rst_a = 1'b0;
        step(9);
        chk_a("before_timeout", 2'b00, 1'b0, 32'd9);
        step(1);
        chk_a("timed_out", 2'b11, 1'b1, 32'd9);
        step(2);
        chk_a("timeout_sticky", 2'b11, 1'b1, 32'd9);

        // simultaneous pass and fail at cycle 3
        rst_a = 1'b1;
        step(1);
        rst_a = 1'b0;
        step(3);
        chk_a("count3", 2'b00, 1'b0, 32'd3);
        pass_a = 1'b1; fail_a = 1'b1;
        step(1);
        chk_a("fail_beats_pass", 2'b10, 1'b1, 32'd3);
        pass_a = 1'b0; fail_a = 1'b0;

        // pass on the timeout edge
        rst_a = 1'b1;
        step(1);
        rst_a = 1'b0;
        step(9);
        pass_a = 1'b1;
        step(1);
        chk_a("pass_beats_timeout", 2'b01, 1'b1, 32'd9);
        pass_a = 1'b0;

        // reset in the middle of a count
        rst_a = 1'b1;
        step(1);
        rst_a = 1'b0;
        step(6);
        chk_a("count6", 2'b00, 1'b0, 32'd6);
        rst_a = 1'b1;
        #1;
        chk_a("midcount_reset", 2'b00, 1'b0, 32'd0);
        step(1);
        rst_a = 1'b0;

        // timeout disabled, 4-bit counter saturates
        chk("b_reset.cnt", 32'(cnt_b), 32'd0);
        rst_b = 1'b0;
        step(14);
        chk("b_count14", 32'(cnt_b), 32'd14);
        step(1);
        chk("b_count15", 32'(cnt_b), 32'd15);
        step(25);
        chk("b_saturated.cnt", 32'(cnt_b), 32'd15);
        chk("b_saturated.status", 32'(status_b), 32'd0);
        chk("b_saturated.done", 32'(done_b), 32'd0);
        pass_b = 1'b1;
        step(1);
        chk("b_passed.status", 32'(status_b), 32'd1);
        chk("b_passed.cnt", 32'(cnt_b), 32'd15);
        pass_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
